shift_seq_ctrl: RTL
===================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; the only supported value is 32.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: requester presents an operation.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operation.
REQ-006 SHALL have port a, input, 32: operand.
REQ-007 SHALL have port shamt, input, 5: shift amount.
REQ-008 SHALL have port type, input, 2: shift type; 00 SRL, 01 SLL, 10 SRA, 11 pass-through.
REQ-009 SHALL have port flush, input, 1: abort any operation in flight.
REQ-010 SHALL have port out_valid, output, 1: result r is valid.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port r, output, 32: result.
REQ-013 SHALL have port busy, output, 1: high in BUSY or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept means in_valid && in_ready on a clock edge.
REQ-016 SHALL on accept latch a into r, shamt into a 5-bit remaining counter, and type into a type register.
REQ-017 SHALL move IDLE->DONE on accept when shamt==0 or type==11, otherwise IDLE->BUSY.
REQ-018 SHALL in each BUSY cycle shift r by step = 1 (see REQ-027), decrement remaining by step, and move to DONE on the edge where remaining reaches 0.
REQ-019 SHALL shift as follows: SRL zero-fills the MSB; SLL zero-fills the LSB; SRA replicates r[31].
REQ-020 SHALL, with step 1, give latency accept edge to out_valid high = shamt+1 cycles for shamt>0 and 1 cycle otherwise.
REQ-021 SHALL assert out_valid only in DONE and hold r stable until out_ready; DONE->IDLE on out_valid && out_ready; in_ready stays low in DONE.
REQ-022 SHALL make flush move any state to IDLE on the next edge with out_valid low; r keeps its value; flush has priority over accept and completion in the same cycle.
REQ-023 SHALL ignore a, shamt and type changes while not IDLE.

Reset
REQ-024 SHALL on rst_n low immediately force state IDLE, r=0, remaining=0, type register=00, out_valid=0, busy=0, in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first edge after rst_n deasserts; reset mid-operation discards the operation with no output.

Configuration
REQ-026 SHALL support macro SHIFT_SEQ_STEP4_EN.
REQ-027 SHALL, with SHIFT_SEQ_STEP4_EN defined, use step = min(4, remaining) per BUSY cycle, giving latency ceil(shamt/4)+1 for shamt>0; without it, step = 1 and behaviour follows REQ-018/REQ-020.

Structure
REQ-028 SHALL take the shift-type encodings (SRL/SLL/SRA/PASS), the FSM state encoding and the XLEN constant from shared package prv32_shift_pkg.
REQ-029 SHALL instantiate one combinational sub-module shift_step (inputs value, step[2:0], type; output shifted value); the FSM and counter stay in shift_seq_ctrl.

Verification
REQ-030 SHALL cover: a=0x80000000, shamt=4, SRA -> out_valid 5 cycles after accept, r=0xF8000000 (STEP4: 2 cycles).
REQ-031 SHALL cover: a=0x12345678, shamt=0, SLL -> out_valid 1 cycle after accept, r=0x12345678, no BUSY cycle.
REQ-032 SHALL cover: a=0x80000000, shamt=31, SRL -> r=0x00000001 after 32 cycles (STEP4: 9 cycles); also a=0x00000001, shamt=31, SLL -> r=0x80000000.
REQ-033 SHALL cover: out_ready low for 3 cycles in DONE -> r and out_valid stable, in_ready low; handshake -> in_ready high next cycle, and a back-to-back accept is taken.
REQ-034 SHALL cover: flush on 2nd BUSY cycle of shamt=10 -> IDLE next edge, out_valid never high, next op (shamt=1, SLL, a=1) gives r=0x00000002.
REQ-035 SHALL cover: rst_n pulled low asynchronously mid-BUSY -> outputs reset without a clock edge; after release in_ready=1 and r=0.

Source files
------------

// File: rtl/prv32_shift_pkg.sv
// Shared encodings for the sequential shifter: shift types, FSM states and operand width.
package prv32_shift_pkg;

    localparam int SHIFT_XLEN = 32;

    typedef enum logic [1:0] {
        SH_SRL  = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } shift_state_e;

    // Operations with nothing to shift skip BUSY and finish on the accept edge.
    function automatic logic completes_at_accept(input logic [4:0] shamt, input logic [1:0] shtype);
        return (shamt == 5'd0) || (shtype == SH_PASS);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..7 bit positions for SRL/SLL/SRA; PASS returns the value.
module shift_step
    import prv32_shift_pkg::*;
#(
    parameter int XLEN = SHIFT_XLEN
) (
    input  logic [XLEN-1:0] value,
    input  logic [2:0]      step,
    input  logic [1:0]      shtype,
    output logic [XLEN-1:0] shifted
);

    always_comb begin
        shifted = value;
        case (shift_type_e'(shtype))
            SH_SRL:  shifted = value >> step;
            SH_SLL:  shifted = value << step;
            SH_SRA:  shifted = $signed(value) >>> step;
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: IDLE/BUSY/DONE FSM around a shift_step datapath with a remaining counter.
// Build option SHIFT_SEQ_STEP4_EN shifts up to four positions per BUSY cycle instead of one.
module shift_seq_ctrl
    import prv32_shift_pkg::*;
#(
    parameter int XLEN = SHIFT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shamt,
    input  logic [1:0]      shtype,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic            busy
);

    shift_state_e    state_reg, state_next;
    shift_type_e     type_reg;
    logic [XLEN-1:0] r_reg;
    logic [4:0]      rem_reg;
    logic            init_reg;
    logic [2:0]      step;
    logic [XLEN-1:0] shifted;
    logic            accept;

    assign accept = in_valid && in_ready;

`ifdef SHIFT_SEQ_STEP4_EN
    assign step = (rem_reg >= 5'd4) ? 3'd4 : rem_reg[2:0];
`else
    assign step = 3'd1;
`endif

    shift_step #(.XLEN(XLEN)) u_step (
        .value   (r_reg),
        .step    (step),
        .shtype  (type_reg),
        .shifted (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            init_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            init_reg  <= 1'b1;
        end
    end

    // Flush overrides every other transition, including an accept in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = completes_at_accept(shamt, shtype) ? ST_DONE : ST_BUSY;
            ST_BUSY: if (rem_reg == {2'b00, step}) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE) && init_reg;
        out_valid = (state_reg == ST_DONE);
        busy      = (state_reg == ST_BUSY) || (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg    <= '0;
            rem_reg  <= '0;
            type_reg <= SH_SRL;
        end else if (!flush) begin
            if (state_reg == ST_IDLE && accept) begin
                r_reg    <= a;
                rem_reg  <= shamt;
                type_reg <= shift_type_e'(shtype);
            end else if (state_reg == ST_BUSY) begin
                r_reg   <= shifted;
                rem_reg <= rem_reg - {2'b00, step};
            end
        end
    end

    assign r = r_reg;

endmodule
